// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: default widths, latency
// bounds and the byte-address to word-index helper.
package mem_pkg;

    localparam int MEM_ADDR_W  = 16;
    localparam int MEM_DATA_W  = 16;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 8;

    // Byte address to word index: drop the byte-select bit (addr[15:1]).
    function automatic logic [MEM_ADDR_W-2:0] wordIndex(input logic [MEM_ADDR_W-1:0] addr);
        return (MEM_ADDR_W-1)'(addr >> 1);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Parameterised synchronous FIFO with a separate occupancy count so that
// full and empty are distinguishable. The head is presented show-ahead;
// when empty, popData holds the most recently popped word (0 after reset).
module resp_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = MEM_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    output logic [WIDTH-1:0]           popData,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slotReg [DEPTH];
    logic [PTR_W-1:0] rdPtrReg;
    logic [PTR_W-1:0] wrPtrReg;
    logic [CNT_W-1:0] countReg;
    logic [WIDTH-1:0] holdReg;
    logic             pushFire;
    logic             popFire;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pushFire = push && (countReg != CNT_W'(DEPTH));
    assign popFire  = pop && (countReg != '0);

    // Storage write; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (pushFire) begin
            slotReg[wrPtrReg] <= pushData;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtrReg <= '0;
            wrPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (pushFire) begin
                wrPtrReg <= nextPtr(wrPtrReg);
            end
            if (popFire) begin
                rdPtrReg <= nextPtr(rdPtrReg);
            end
            if (pushFire && !popFire) begin
                countReg <= countReg + CNT_W'(1);
            end else if (popFire && !pushFire) begin
                countReg <= countReg - CNT_W'(1);
            end
        end
    end

    // Remember the last popped word so the output is stable while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdReg <= '0;
        end else if (popFire) begin
            holdReg <= slotReg[rdPtrReg];
        end
    end

    assign popData = (countReg != '0) ? slotReg[rdPtrReg] : holdReg;
    assign count   = countReg;

endmodule

// File: rtl/mem_resp_pipe.sv
// Main-memory responder: word-organised storage, fixed-latency read
// pipeline and a credit-controlled response FIFO.
// Optional statistics counters are enabled with `define MEM_RESP_STATS_EN.
module mem_resp_pipe
    import mem_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int LATENCY   = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_stall
`endif
);

    localparam int NSTG  = LATENCY - 1;
    localparam int OUT_W = $clog2(RSP_DEPTH + 1);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("mem_resp_pipe: LATENCY out of range");
    end
    if (RSP_DEPTH < 1) begin : g_bad_depth
        $error("mem_resp_pipe: RSP_DEPTH must be at least 1");
    end

    logic [DATA_W-1:0]      memArray [2**(ADDR_W-1)];
    logic [ADDR_W-2:0]      wordIdx;
    logic [OUT_W-1:0]       outstandingReg;
    logic [OUT_W-1:0]       outstandingNext;
    logic                   acceptRd;
    logic                   acceptWr;
    logic                   popFire;
    logic                   pushValid;
    logic [DATA_W-1:0]      pushData;
    logic [OUT_W-1:0]       fifoCount;

    if (ADDR_W == MEM_ADDR_W) begin : g_idx_default
        assign wordIdx = wordIndex(req_addr);
    end else begin : g_idx_generic
        assign wordIdx = (ADDR_W-1)'(req_addr >> 1);
    end

    // Ready depends only on the credit counter and reset, never on req_valid/rsp_ready.
    assign req_ready = (outstandingReg < OUT_W'(RSP_DEPTH)) && !rst;
    assign acceptRd  = req_valid && req_ready && !req_we;
    assign acceptWr  = req_valid && req_ready && req_we;
    assign rsp_valid = (fifoCount != '0);
    assign popFire   = rsp_valid && rsp_ready;

    // Write port; array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (acceptWr) begin
            memArray[wordIdx] <= req_wdata;
        end
    end

    if (NSTG == 0) begin : g_no_pipe
        assign pushValid = acceptRd;
        assign pushData  = memArray[wordIdx];
    end else begin : g_pipe
        for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
            logic              validReg;
            logic [DATA_W-1:0] dataReg;
            if (gi == 0) begin : g_head
                // First stage samples the array, freezing the read data against later writes.
                always_ff @(posedge clk) begin
                    validReg <= rst ? 1'b0 : acceptRd;
                    if (acceptRd) begin
                        dataReg <= memArray[wordIdx];
                    end
                end
            end else begin : g_body
                // Plain valid/data shift stage; valid bits flush on reset.
                always_ff @(posedge clk) begin
                    validReg <= rst ? 1'b0 : g_stg[gi-1].validReg;
                    dataReg  <= g_stg[gi-1].dataReg;
                end
            end
        end
        assign pushValid = g_stg[NSTG-1].validReg;
        assign pushData  = g_stg[NSTG-1].dataReg;
    end

    // Credits cover pipeline plus FIFO, so the FIFO can never overflow.
    resp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushValid),
        .pushData (pushData),
        .pop      (rsp_ready),
        .popData  (rsp_data),
        .count    (fifoCount)
    );

    // Next credit count: +1 per accepted read, -1 per pop, unchanged when both.
    always_comb begin
        outstandingNext = outstandingReg;
        case ({acceptRd, popFire})
            2'b10:   outstandingNext = outstandingReg + OUT_W'(1);
            2'b01:   outstandingNext = outstandingReg - OUT_W'(1);
            default: outstandingNext = outstandingReg;
        endcase
    end

    // Credit counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstandingReg <= '0;
        end else begin
            outstandingReg <= outstandingNext;
        end
    end

`ifdef MEM_RESP_STATS_EN
    logic [31:0] statReadsReg;
    logic [31:0] statWritesReg;
    logic [31:0] statStallReg;

    // Saturating event counters for accepted requests and stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            statReadsReg  <= '0;
            statWritesReg <= '0;
            statStallReg  <= '0;
        end else begin
            if (acceptRd && statReadsReg != '1) begin
                statReadsReg <= statReadsReg + 32'd1;
            end
            if (acceptWr && statWritesReg != '1) begin
                statWritesReg <= statWritesReg + 32'd1;
            end
            if (req_valid && !req_ready && statStallReg != '1) begin
                statStallReg <= statStallReg + 32'd1;
            end
        end
    end

    assign stat_reads  = statReadsReg;
    assign stat_writes = statWritesReg;
    assign stat_stall  = statStallReg;
`endif

endmodule

// File: tb/tb_mem_resp_pipe.sv
// Directed bench for mem_resp_pipe (LATENCY=4, RSP_DEPTH=4): a cycle-by-cycle
// vector table plus a hand-written reset-in-flight sequence.
// Stat checks are compiled when MEM_RESP_STATS_EN is defined.
module tb_mem_resp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_ready;
`ifdef MEM_RESP_STATS_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
    logic [31:0] stat_stall;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_resp_pipe #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .LATENCY   (4),
        .RSP_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
`ifdef MEM_RESP_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_stall  (stat_stall)
`endif
    );

    typedef struct {
        logic        v;
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
        logic        rr;
        logic        eRdy;
        logic        eVal;
        logic        eChk;
        logic [15:0] eD;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d,
                       input logic rr, input logic eRdy, input logic eVal, input logic eChk,
                       input logic [15:0] eD);
        vec_t x;
        x.v = v; x.we = we; x.a = a; x.d = d; x.rr = rr;
        x.eRdy = eRdy; x.eVal = eVal; x.eChk = eChk; x.eD = eD;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int got;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        // Reset state
        @(negedge clk); #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_data", {16'd0, rsp_data}, 32'd0);

        //  v we addr     wdata    rr rdy val chk data
        add(1, 1, 16'h0010, 16'h1234, 1, 1, 0, 1, 16'h0000);  // c0
        add(1, 1, 16'h0000, 16'h1111, 1, 1, 0, 0, 16'h0000);
        add(1, 1, 16'h0002, 16'h2222, 1, 1, 0, 0, 16'h0000);
        add(1, 1, 16'h0004, 16'h3333, 1, 1, 0, 0, 16'h0000);
        add(1, 1, 16'h0006, 16'h4444, 1, 1, 0, 0, 16'h0000);
        add(1, 1, 16'h0020, 16'hAAAA, 1, 1, 0, 0, 16'h0000);  // c5
        add(1, 0, 16'h0010, 16'h0000, 1, 1, 0, 0, 16'h0000);  // c6 read T=6
        add(1, 0, 16'h0011, 16'h0000, 1, 1, 0, 0, 16'h0000);  // c7 odd address, same word
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h1234);  // c10 = T+4
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h1234);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h1234);  // empty: data held
        // streaming
        add(1, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000);  // c13
        add(1, 0, 16'h0002, 16'h0000, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0004, 16'h0000, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0006, 16'h0000, 1, 1, 0, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 1, 16'h1111);  // c17: 4 outstanding
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h2222);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h3333);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h4444);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h4444);  // c21
        // back-pressure
        add(1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000);  // c22
        add(1, 0, 16'h0002, 16'h0000, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0004, 16'h0000, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0006, 16'h0000, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0010, 16'h0000, 0, 0, 1, 1, 16'h1111);  // c26 stalled
        add(1, 0, 16'h0010, 16'h0000, 0, 0, 1, 1, 16'h1111);
        add(1, 0, 16'h0010, 16'h0000, 0, 0, 1, 1, 16'h1111);
        add(1, 0, 16'h0010, 16'h0000, 1, 0, 1, 1, 16'h1111);  // c29 first pop
        add(1, 0, 16'h0010, 16'h0000, 1, 1, 1, 1, 16'h2222);  // c30 accepted
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h3333);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h4444);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h4444);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h1234);  // c34 = 30+4
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h1234);
        // read then write same word
        add(1, 0, 16'h0020, 16'h0000, 1, 1, 0, 0, 16'h0000);  // c36
        add(1, 1, 16'h0020, 16'h5555, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0020, 16'h0000, 1, 1, 0, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'hAAAA);  // c40
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'hAAAA);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h5555);
        add(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h5555);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = 1'b0;
            req_valid = vecs[i].v; req_we = vecs[i].we;
            req_addr = vecs[i].a; req_wdata = vecs[i].d; rsp_ready = vecs[i].rr;
            #1;
            $display("vec %0d: v=%0d we=%0d addr=%h wdata=%h rr=%0d -> ready=%0d rsp_valid=%0d rsp_data=%h",
                     i, req_valid, req_we, req_addr, req_wdata, rsp_ready, req_ready, rsp_valid, rsp_data);
            chk($sformatf("c%0d req_ready", i), {31'd0, req_ready}, {31'd0, vecs[i].eRdy});
            chk($sformatf("c%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].eVal});
            if (vecs[i].eChk) begin
                chk($sformatf("c%0d rsp_data", i), {16'd0, rsp_data}, {16'd0, vecs[i].eD});
            end
        end

`ifdef MEM_RESP_STATS_EN
        @(negedge clk); req_valid = 1'b0; #1;
        chk("stat_writes", stat_writes, 32'd7);
        chk("stat_reads", stat_reads, 32'd13);
        chk("stat_stall", stat_stall, 32'd4);
`endif

        // Reset with three reads in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; rsp_ready = 1'b1;
            req_addr = (k == 0) ? 16'h0010 : 16'(2 * k);
            #1;
            $display("midflight read %0d: addr=%h ready=%0d", k, req_addr, req_ready);
            chk($sformatf("midflight accept %0d", k), {31'd0, req_ready}, 32'd1);
        end
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; #1;
        chk("rst pulse req_ready", {31'd0, req_ready}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rst = 1'b0; #1;
            chk($sformatf("post-rst %0d req_ready", k), {31'd0, req_ready}, 32'd1);
            chk($sformatf("post-rst %0d rsp_valid", k), {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("post-rst %0d rsp_data", k), {16'd0, rsp_data}, 32'd0);
`ifdef MEM_RESP_STATS_EN
            if (k == 0) begin
                chk("post-rst stat_reads", stat_reads, 32'd0);
                chk("post-rst stat_writes", stat_writes, 32'd0);
                chk("post-rst stat_stall", stat_stall, 32'd0);
            end
`endif
        end

        // Full credit window must be available again after the flush
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; rsp_ready = 1'b0; #1;
            $display("post-rst read %0d: addr=%h ready=%0d", k, req_addr, req_ready);
            chk($sformatf("post-rst credit %0d", k), {31'd0, req_ready}, 32'd1);
        end
        @(negedge clk);
        req_valid = 1'b0; #1;
        chk("post-rst full req_ready", {31'd0, req_ready}, 32'd0);

        rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 12 && got < 4; k++) begin
            if (rsp_valid) begin
                $display("drain rsp %0d: data=%h", got, rsp_data);
                chk($sformatf("drain data %0d", got), {16'd0, rsp_data}, 32'h1234);
                got++;
            end
            @(negedge clk); #1;
        end
        chk("drain count", got, 32'd4);
        chk("drain final rsp_valid", {31'd0, rsp_valid}, 32'd0);
`ifdef MEM_RESP_STATS_EN
        chk("final stat_reads", stat_reads, 32'd4);
        chk("final stat_stall", stat_stall, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_resp_pipe.md
Name: mem_resp_pipe

Overview:
- Main-memory responder at the far end of the cache fill/writeback interface. It services requests from the I-cache and D-cache miss handlers.
- Word-organised 16-bit storage with a fixed, pipelined read latency.
- Read responses are buffered in a response FIFO under credit control, so the requester may back-pressure without data loss.
- Used both as the CPU's backing store and as a standalone bench target.

Parameters:
- ADDR_W, 16, byte-address width; word index = req_addr[ADDR_W-1:1].
- DATA_W, 16, word width.
- LATENCY, 4, cycles from read acceptance to earliest rsp_valid; legal range 1..8.
- RSP_DEPTH, 4, maximum outstanding reads (in pipeline plus in FIFO); must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; bit 0 ignored.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  request accepted when req_valid && req_ready at the clock edge.
- rsp_valid  out  1  read data available at FIFO head.
- rsp_data  out  DATA_W  read data.
- rsp_ready  in  1  requester consumes the head when rsp_valid && rsp_ready.

Behaviour:
- Reset values: req_ready=0 during rst; req_ready=1 from the first cycle after rst deasserts. rsp_valid=0, rsp_data=0, FIFO empty, pipeline empty, outstanding=0.
- Memory array contents are NOT cleared by rst.
- req_ready = (outstanding < RSP_DEPTH) && !rst. It is driven from registered state only: no combinational path from req_valid or rsp_ready.
- req_ready gates reads and writes alike, which keeps request ordering strict.
- Write, accepted in cycle T: mem[word] is updated at the edge ending T. No response is generated and outstanding is unchanged.
- Read, accepted in cycle T:
  - mem[word] is sampled at the edge ending T. A later write to the same word cannot alter the data already in flight.
  - The data traverses a LATENCY-1 stage valid/data shift pipeline, then enters the FIFO.
  - rsp_valid rises in cycle T+LATENCY if the FIFO was empty and not stalled.
  - outstanding increments on acceptance.
- Back-to-back reads at one per cycle produce one response per cycle while rsp_ready=1.
- Pop: when rsp_valid && rsp_ready, the FIFO head advances and outstanding decrements.
  - If an accept and a pop occur in the same cycle, outstanding is unchanged.
- Full: outstanding==RSP_DEPTH drops req_ready. It reasserts the cycle after the first pop.
  - The FIFO can never overflow, because credits cover pipeline plus FIFO.
- Empty FIFO: rsp_valid=0 and rsp_data holds its last value. rsp_ready is ignored.
- FIFO pointers wrap modulo RSP_DEPTH. The count is tracked separately so that full and empty are distinguishable.
- rst mid-operation flushes the pipeline, the FIFO and outstanding. Reads in flight are dropped. A write presented during rst is not performed.
- No protocol FSM: the state is outstanding (0..RSP_DEPTH), the pipeline valid bits and the FIFO rd/wr/count.

Optional Feature:
- MEM_RESP_STATS_EN defined:
  - Adds 32-bit outputs stat_reads, stat_writes and stat_stall.
  - stat_reads and stat_writes count accepted requests.
  - stat_stall counts cycles with req_valid && !req_ready.
  - All three clear on rst and saturate at 0xFFFFFFFF.
- MEM_RESP_STATS_EN undefined: these ports and their counters do not exist.

Decomposition:
- Shared package mem_pkg holds:
  - DATA_W and ADDR_W defaults.
  - The word-index extraction function, addr to addr[15:1].
  - The LATENCY bounds constants.
- One sub-module, resp_fifo: a parameterised synchronous FIFO (depth, width) with push/pop/count, instantiated once for responses.

Test Plan:
- Reset then write: write 0x1234 to addr 0x0010, then read 0x0010 accepted at cycle T -> rsp_valid in cycle T+4, rsp_data=0x1234. Reading addr 0x0011 returns the same word.
- Streaming: reads of 0x0000,0x0002,0x0004,0x0006 on consecutive cycles with rsp_ready=1 -> four responses on consecutive cycles in order, req_ready stays 1.
- Back-pressure: rsp_ready=0, issue 5 reads -> req_ready drops after the 4th acceptance and the 5th is stalled. Raise rsp_ready -> req_ready=1 one cycle after the first pop, and all 5 responses arrive in order.
- Read then write same word: read 0x0020 (holding 0xAAAA), then on the next cycle write 0x5555 to 0x0020 -> response returns 0xAAAA. A subsequent read returns 0x5555.
- Reset mid-flight: 3 reads accepted, rst pulsed for 1 cycle -> no rsp_valid afterwards, outstanding=0, req_ready=1 after rst. Previously written data is still readable.
- Stats (MEM_RESP_STATS_EN): 2 writes, 5 reads and 3 stall cycles -> stat_writes=2, stat_reads=5, stat_stall=3; all zero after rst.
